// File: rtl/banco_registradores_sb.sv
// banco_registradores_sb: register file with per-register pending scoreboard.
// Two combinational read ports, one clocked write port, issue-driven pending
// bits and a registered pending-bit count. Register 0 reads as zero and is
// never pending.
// Optional build macro: BREG_BYPASS_EN (write-through bypass on both read ports).

// One register plus its pending bit; the address decode lives in the parent.
module banco_registradores_sb_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              set,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic              pend
);
  // Data and pending bit; an issue in the same cycle as a writeback wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (we) q <= din;
      if (set)     pend <= 1'b1;
      else if (we) pend <= 1'b0;
    end
  end
endmodule

module banco_registradores_sb #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_escrita,
  input  logic [ADDR_W-1:0] endereco_regd,
  input  logic [DATA_W-1:0] dado_escrita,
  input  logic              emite,
  input  logic [ADDR_W-1:0] endereco_emite,
  input  logic [ADDR_W-1:0] endereco_reg1,
  input  logic [ADDR_W-1:0] endereco_reg2,
  output logic [DATA_W-1:0] valor_reg1,
  output logic [DATA_W-1:0] valor_reg2,
  output logic              pendente_reg1,
  output logic              pendente_reg2,
  output logic [ADDR_W:0]   num_pendentes
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             pend;

  // Register 0 is hardwired: no cell, constant zero data, never pending.
  assign regs[0] = '0;
  assign pend[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_reg
      banco_registradores_sb_cell #(.DATA_W(DATA_W)) u_cell (
        .clock (clock),
        .reset (reset),
        .we    (reg_escrita && (endereco_regd == ADDR_W'(r))),
        .set   (emite && (endereco_emite == ADDR_W'(r))),
        .din   (dado_escrita),
        .q     (regs[r]),
        .pend  (pend[r])
      );
    end
  endgenerate

  // At most one set and one clear per cycle, so the count moves by -1..+1.
  // A clear is suppressed when the same register is re-issued this cycle.
  logic inc, dec;
  always_comb begin
    inc = emite && (endereco_emite != '0) && !pend[endereco_emite];
    dec = reg_escrita && (endereco_regd != '0) && pend[endereco_regd] &&
          !(emite && (endereco_emite == endereco_regd));
  end

  // Pending count tracks popcount(pend) incrementally; cannot exceed NUM_REGS-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            num_pendentes <= '0;
    else if (inc && !dec) num_pendentes <= num_pendentes + (ADDR_W+1)'(1);
    else if (dec && !inc) num_pendentes <= num_pendentes - (ADDR_W+1)'(1);
  end

  // Read ports, optionally forwarding the in-flight writeback.
  always_comb begin
    valor_reg1    = regs[endereco_reg1];
    valor_reg2    = regs[endereco_reg2];
    pendente_reg1 = pend[endereco_reg1];
    pendente_reg2 = pend[endereco_reg2];
`ifdef BREG_BYPASS_EN
    if (reg_escrita && (endereco_regd == endereco_reg1) && (endereco_reg1 != '0)) begin
      valor_reg1    = dado_escrita;
      pendente_reg1 = emite && (endereco_emite == endereco_reg1);
    end
    if (reg_escrita && (endereco_regd == endereco_reg2) && (endereco_reg2 != '0)) begin
      valor_reg2    = dado_escrita;
      pendente_reg2 = emite && (endereco_emite == endereco_reg2);
    end
`endif
  end
endmodule

// File: tb/tb_banco_registradores_sb.sv
// Self-checking bench for banco_registradores_sb: directed scenarios followed
// by randomized traffic, all compared against a plain array model.
module tb_banco_registradores_sb;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  logic              clock = 1'b0;
  logic              reset;
  logic              reg_escrita;
  logic [ADDR_W-1:0] endereco_regd;
  logic [DATA_W-1:0] dado_escrita;
  logic              emite;
  logic [ADDR_W-1:0] endereco_emite;
  logic [ADDR_W-1:0] endereco_reg1;
  logic [ADDR_W-1:0] endereco_reg2;
  logic [DATA_W-1:0] valor_reg1;
  logic [DATA_W-1:0] valor_reg2;
  logic              pendente_reg1;
  logic              pendente_reg2;
  logic [ADDR_W:0]   num_pendentes;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents and pending flags as plain arrays.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  bit                m_pend [NUM_REGS];

  banco_registradores_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clock          (clock),
    .reset          (reset),
    .reg_escrita    (reg_escrita),
    .endereco_regd  (endereco_regd),
    .dado_escrita   (dado_escrita),
    .emite          (emite),
    .endereco_emite (endereco_emite),
    .endereco_reg1  (endereco_reg1),
    .endereco_reg2  (endereco_reg2),
    .valor_reg1     (valor_reg1),
    .valor_reg2     (valor_reg2),
    .pendente_reg1  (pendente_reg1),
    .pendente_reg2  (pendente_reg2),
    .num_pendentes  (num_pendentes)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] exp_val(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef BREG_BYPASS_EN
    if (reg_escrita && endereco_regd == a) return dado_escrita;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
`ifdef BREG_BYPASS_EN
    if (reg_escrita && endereco_regd == a) return emite && endereco_emite == a;
`endif
    return m_pend[a];
  endfunction

  task automatic check_comb(input string tag);
    chk({tag, ".valor1"}, valor_reg1, exp_val(endereco_reg1));
    chk({tag, ".valor2"}, valor_reg2, exp_val(endereco_reg2));
    chk({tag, ".pend1"}, DATA_W'(pendente_reg1), DATA_W'(exp_pend(endereco_reg1)));
    chk({tag, ".pend2"}, DATA_W'(pendente_reg2), DATA_W'(exp_pend(endereco_reg2)));
  endtask

  // Inputs are already applied (1 time unit after an edge). Check read side
  // mid-cycle, take the edge, apply it to the model, then check the count.
  task automatic tick(input string tag);
    #3;
    check_comb(tag);
    @(posedge clock);
    if (reg_escrita && endereco_regd != 0) begin
      m_regs[endereco_regd] = dado_escrita;
      m_pend[endereco_regd] = 1'b0;
    end
    if (emite && endereco_emite != 0) m_pend[endereco_emite] = 1'b1;
    #1;
    chk({tag, ".num"}, DATA_W'(num_pendentes), DATA_W'(model_count()));
  endtask

  task automatic idle_inputs();
    reg_escrita = 0; endereco_regd = '0; dado_escrita = '0;
    emite = 0; endereco_emite = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    endereco_reg1 = '0; endereco_reg2 = '0;
    model_reset();
    #12;
    chk("rst.valor1", valor_reg1, '0);
    chk("rst.pend1", DATA_W'(pendente_reg1), '0);
    chk("rst.num", DATA_W'(num_pendentes), '0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Write r5 and issue r6, then async reset mid-cycle.
    reg_escrita = 1; endereco_regd = 5; dado_escrita = 32'hDEADBEEF;
    emite = 1; endereco_emite = 6;
    tick("t1.wr");
    idle_inputs(); endereco_reg1 = 5; endereco_reg2 = 6;
    #2;
    chk("t1.pre_valor1", valor_reg1, 32'hDEADBEEF);
    chk("t1.pre_num", DATA_W'(num_pendentes), 1);
    reset = 1'b1; model_reset();
    #1;
    chk("t1.rst_valor1", valor_reg1, '0);
    chk("t1.rst_pend2", DATA_W'(pendente_reg2), '0);
    chk("t1.rst_num", DATA_W'(num_pendentes), '0);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // r0 write and issue are ignored.
    reg_escrita = 1; endereco_regd = 0; dado_escrita = 32'h12345678;
    emite = 1; endereco_emite = 0; endereco_reg1 = 0; endereco_reg2 = 0;
    tick("t2.r0");
    idle_inputs();
    #2;
    chk("t2.valor1", valor_reg1, '0);
    chk("t2.valor2", valor_reg2, '0);
    chk("t2.pend1", DATA_W'(pendente_reg1), '0);
    chk("t2.num", DATA_W'(num_pendentes), '0);
    @(posedge clock); #1;

    // Issue r7, then write it back.
    emite = 1; endereco_emite = 7; endereco_reg1 = 7;
    tick("t3.iss");
    idle_inputs();
    #2;
    chk("t3.pend1", DATA_W'(pendente_reg1), 1);
    chk("t3.num1", DATA_W'(num_pendentes), 1);
    @(posedge clock); #1;
    reg_escrita = 1; endereco_regd = 7; dado_escrita = 32'hA5A5A5A5;
    tick("t3.wb");
    idle_inputs();
    #2;
    chk("t3.pend1_after", DATA_W'(pendente_reg1), 0);
    chk("t3.valor1_after", valor_reg1, 32'hA5A5A5A5);
    chk("t3.num0", DATA_W'(num_pendentes), 0);
    @(posedge clock); #1;

    // Issue r3, then same-cycle issue+write of r3: stays pending, data stored.
    emite = 1; endereco_emite = 3;
    tick("t4.iss");
    reg_escrita = 1; endereco_regd = 3; dado_escrita = 32'h11;
    emite = 1; endereco_emite = 3; endereco_reg1 = 3;
    tick("t4.both");
    idle_inputs();
    #2;
    chk("t4.pend1", DATA_W'(pendente_reg1), 1);
    chk("t4.valor1", valor_reg1, 32'h11);
    chk("t4.num", DATA_W'(num_pendentes), 1);
    @(posedge clock); #1;

    // Write r9 while reading it on port 2.
    reg_escrita = 1; endereco_regd = 9; dado_escrita = 32'h55; endereco_reg2 = 9;
    #2;
`ifdef BREG_BYPASS_EN
    chk("t5.same_cycle", valor_reg2, 32'h55);
`else
    chk("t5.same_cycle", valor_reg2, 32'h0);
`endif
    #0 tick("t5.wr");
    idle_inputs();
    #2;
    chk("t5.after", valor_reg2, 32'h55);
    @(posedge clock); #1;

    // Clear the leftover r3 pending, then fill and drain the scoreboard.
    reg_escrita = 1; endereco_regd = 3; dado_escrita = 32'h33;
    tick("t6.clr");
    idle_inputs();
    for (int r = 1; r < NUM_REGS; r++) begin
      emite = 1; endereco_emite = ADDR_W'(r); endereco_reg1 = ADDR_W'(r);
      tick("t6.fill");
    end
    idle_inputs();
    chk("t6.full", DATA_W'(num_pendentes), NUM_REGS-1);
    for (int r = 1; r < NUM_REGS; r++) begin
      reg_escrita = 1; endereco_regd = ADDR_W'(r); dado_escrita = $urandom;
      endereco_reg2 = ADDR_W'(r);
      tick("t6.drain");
    end
    idle_inputs();
    chk("t6.empty", DATA_W'(num_pendentes), 0);

    // Randomized traffic; small address pool to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      reg_escrita    = ($urandom_range(0, 1) == 1);
      endereco_regd  = ADDR_W'($urandom_range(0, 7));
      dado_escrita   = $urandom;
      emite          = ($urandom_range(0, 2) != 0);
      endereco_emite = ADDR_W'($urandom_range(0, 7));
      endereco_reg1  = ADDR_W'($urandom_range(0, 7));
      endereco_reg2  = ($urandom_range(0, 3) == 0) ? endereco_regd : ADDR_W'($urandom_range(0, 7));
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
